fetch_controller: RTL

//  Sequences the stage-3 program_counter and instruction-memory fetch port for the 7-stage core.

---
 rtl/fetch_controller_pkg.sv | 46 ++++
 rtl/fetch_controller_redirect_arbiter.sv | 40 ++++
 rtl/fetch_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the fetch controller slice.
// Contents: word type, boot address, pipeline stage numbers of each redirect
// source, shadow window length, FSM and redirect-source enums, and a helper
// that builds the flush mask for a given redirect source.
package fetch_controller_pkg;

  typedef logic [31:0] word_t;

  localparam int    NUM_STAGES    = 7;
  localparam int    JMP_STAGE     = 3;
  localparam int    BR_STAGE      = 5;
  localparam int    TRAP_STAGE    = 7;
  localparam int    SHADOW_CYCLES = 1;
  localparam int    SHADOW_W      = $clog2(SHADOW_CYCLES + 1);
  localparam word_t BOOT_ADDRESS  = 32'h0000_1000;

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    MEM_WAIT,
    REDIRECT,
    HALT
  } fetch_state_e;

  // Declaration order is priority order, so sources compare with < and >.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_JMP,
    SRC_BR,
    SRC_TRAP
  } redirect_src_e;

  // A redirect raised in stage S squashes every younger stage 1..S-1,
  // i.e. flush_mask bits [0..S-2].
  function automatic logic [NUM_STAGES-1:0] flush_for(input redirect_src_e src);
    logic [NUM_STAGES-1:0] mask;
    case (src)
      SRC_TRAP: mask = NUM_STAGES'((1 << (TRAP_STAGE - 1)) - 1);
      SRC_BR:   mask = NUM_STAGES'((1 << (BR_STAGE - 1)) - 1);
      SRC_JMP:  mask = NUM_STAGES'((1 << (JMP_STAGE - 1)) - 1);
      default:  mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/fetch_controller_redirect_arbiter.sv
// Combinational priority select among the three PC redirect sources.
// Ports:
//   trap_valid/trap_vector  stage-7 trap redirect (never masked)
//   br_valid/br_target      stage-5 branch mispredict redirect
//   jmp_valid/jmp_target    stage-3 jump/jalr redirect
//   shadow_active           1 while younger sources must be ignored
//   src                     winning source (SRC_NONE when nothing wins)
//   target                  target address of the winning source
module fetch_controller_redirect_arbiter
  import fetch_controller_pkg::*;
(
  input  logic          trap_valid,
  input  word_t         trap_vector,
  input  logic          br_valid,
  input  word_t         br_target,
  input  logic          jmp_valid,
  input  word_t         jmp_target,
  input  logic          shadow_active,
  output redirect_src_e src,
  output word_t         target
);

  // trap > br > jmp; the shadow window only hides the two younger sources
  // because they may be wrong-path instructions of the redirect just taken.
  always_comb begin
    src    = SRC_NONE;
    target = '0;
    if (trap_valid) begin
      src    = SRC_TRAP;
      target = trap_vector;
    end else if (!shadow_active && br_valid) begin
      src    = SRC_BR;
      target = br_target;
    end else if (!shadow_active && jmp_valid) begin
      src    = SRC_JMP;
      target = jmp_target;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch controller: sequences the stage-3 program counter and the
// instruction-memory fetch port, arbitrates PC redirects, holds a redirect
// that arrives while imem is busy, and drives per-stage flush.
// Ports:
//   clock, reset (async, active-low)
//   hazard_stall, halt_req, imem_ready         control inputs
//   trap/br/jmp _valid + target                redirect sources
//   pc_now                                     current PC
//   imem_req, fetch_addr                       imem fetch port
//   pc_stall, pc_load, pc_load_addr            program counter control
//   flush_mask                                 bit i squashes stage i+1
//   halted                                     controller is in HALT
module fetch_controller
  import fetch_controller_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hazard_stall,
  input  logic                  halt_req,
  input  logic                  imem_ready,
  input  logic                  trap_valid,
  input  word_t                 trap_vector,
  input  logic                  br_valid,
  input  word_t                 br_target,
  input  logic                  jmp_valid,
  input  word_t                 jmp_target,
  input  word_t                 pc_now,
  output logic                  imem_req,
  output word_t                 fetch_addr,
  output logic                  pc_stall,
  output logic                  pc_load,
  output word_t                 pc_load_addr,
  output logic [NUM_STAGES-1:0] flush_mask,
  output logic                  halted
);

  fetch_state_e          state, state_nxt;
  redirect_src_e         arb_src, pend_src, pend_src_nxt;
  word_t                 arb_target, pend_addr, pend_addr_nxt, held_addr;
  word_t                 load_addr_nxt;
  logic                  pend_valid, pend_valid_nxt;
  logic                  load_nxt, take;
  logic [NUM_STAGES-1:0] flush_nxt;
  logic [SHADOW_W-1:0]   shadow_cnt;

  fetch_controller_redirect_arbiter u_arbiter (
    .trap_valid    (trap_valid),
    .trap_vector   (trap_vector),
    .br_valid      (br_valid),
    .br_target     (br_target),
    .jmp_valid     (jmp_valid),
    .jmp_target    (jmp_target),
    .shadow_active (shadow_cnt != '0),
    .src           (arb_src),
    .target        (arb_target)
  );

  // Whether the arbiter winner is acted on in the current state. While a
  // redirect is pending only a strictly higher priority source replaces it;
  // in HALT only a trap wakes the controller.
  always_comb begin
    take = 1'b0;
    case (state)
      RUN, MEM_WAIT: take = (arb_src != SRC_NONE);
      REDIRECT:      take = (arb_src > pend_src);
      HALT:          take = (arb_src == SRC_TRAP);
      default:       take = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_nxt;
  end

  // Next state plus next values of the pending register and the registered
  // PC-load/flush outputs. A taken redirect is applied before a halt request.
  always_comb begin
    state_nxt      = state;
    pend_valid_nxt = pend_valid;
    pend_src_nxt   = pend_src;
    pend_addr_nxt  = pend_addr;
    load_nxt       = 1'b0;
    load_addr_nxt  = pc_load_addr;
    flush_nxt      = take ? flush_for(arb_src) : '0;
    case (state)
      BOOT: begin
        state_nxt     = RUN;
        load_nxt      = 1'b1;
        load_addr_nxt = BOOT_ADDRESS;
        flush_nxt     = '1;
      end
      RUN, HALT: begin
        if (take) begin
          if (imem_ready) begin
            load_nxt      = 1'b1;
            load_addr_nxt = arb_target;
            state_nxt     = RUN;
          end else begin
            pend_valid_nxt = 1'b1;
            pend_src_nxt   = arb_src;
            pend_addr_nxt  = arb_target;
            state_nxt      = REDIRECT;
          end
        end else if (state == HALT) begin
          if (!halt_req) state_nxt = RUN;
        end else if (halt_req) begin
          state_nxt = HALT;
        end else if (!imem_ready) begin
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (take) begin
          pend_valid_nxt = 1'b1;
          pend_src_nxt   = arb_src;
          pend_addr_nxt  = arb_target;
          state_nxt      = REDIRECT;
        end else if (imem_ready) begin
          state_nxt = RUN;
        end
      end
      REDIRECT: begin
        if (take) begin
          pend_src_nxt  = arb_src;
          pend_addr_nxt = arb_target;
        end
        // A replacement arriving in the same cycle imem frees up is the one loaded.
        if (imem_ready && pend_valid) begin
          load_nxt       = 1'b1;
          load_addr_nxt  = take ? arb_target : pend_addr;
          pend_valid_nxt = 1'b0;
          pend_src_nxt   = SRC_NONE;
          state_nxt      = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Datapath registers: pending redirect, shadow window, held fetch address
  // and the registered PC-load/flush outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_valid   <= 1'b0;
      pend_src     <= SRC_NONE;
      pend_addr    <= '0;
      shadow_cnt   <= '0;
      held_addr    <= BOOT_ADDRESS;
      pc_load      <= 1'b0;
      pc_load_addr <= BOOT_ADDRESS;
      flush_mask   <= '1;
    end else begin
      pend_valid   <= pend_valid_nxt;
      pend_src     <= pend_src_nxt;
      pend_addr    <= pend_addr_nxt;
      held_addr    <= fetch_addr;
      pc_load      <= load_nxt;
      pc_load_addr <= load_addr_nxt;
      flush_mask   <= flush_nxt;
      if (take)                  shadow_cnt <= SHADOW_W'(SHADOW_CYCLES);
      else if (shadow_cnt != '0) shadow_cnt <= shadow_cnt - SHADOW_W'(1);
    end
  end

  // Moore outputs. imem_req depends on state only, so imem_ready never
  // reaches it combinationally; outside RUN the last fetch address is held.
  always_comb begin
    imem_req   = (state == RUN) || (state == MEM_WAIT) || (state == REDIRECT);
    halted     = (state == HALT);
    pc_stall   = hazard_stall || (state != RUN) || !imem_ready;
    fetch_addr = (state == RUN) ? pc_now : held_addr;
  end

endmodule
